// File: rtl/image_stream_pkg.sv
// Shared types for the image stream reader: FSM states and per-pixel sideband.
// ST_GAP exists only when IMAGE_STREAM_LINE_GAP_EN is defined.
package image_stream_pkg;

  localparam int SB_CHAN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
`ifdef IMAGE_STREAM_LINE_GAP_EN
    , ST_GAP = 2'd3
`endif
  } state_t;

  typedef struct packed {
    logic                 sof;
    logic                 eol;
    logic                 eof;
    logic [SB_CHAN_W-1:0] chan;
  } pix_sb_t;

endpackage

// File: rtl/image_rom_sync.sv
// Generic DATA_W x 2**ADDR_W synchronous ROM, one cycle read latency.
// Empty INIT_FILE selects a ramp (word i holds i), which the pixel stream relies on in simulation.
module image_rom_sync #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data;

  if (INIT_FILE == "") begin : g_ramp
    always_ff @(posedge clk) r_data <= DATA_W'(i_addr);
  end else begin : g_vendor
    // File-backed contents live in the vendor ROM macro; this stand-in reads as zero.
    always_ff @(posedge clk) r_data <= '0;
  end

  assign o_data = r_data;

endmodule

// File: rtl/image_stream_reader.sv
// Streams a channel-planar, row-major image from ROM as a valid/ready pixel stream with markers.
// Define IMAGE_STREAM_LINE_GAP_EN to insert LINE_GAP blanking cycles after each row.
//
// state    | meaning
// ST_IDLE  | waiting for pic_start
// ST_RUN   | issuing ROM reads while the skid FIFO has room
// ST_DRAIN | all addresses issued, emptying in-flight read and FIFO
// ST_GAP   | horizontal blanking after a row (optional feature only)
module image_stream_reader
  import image_stream_pkg::*;
#(
`ifdef IMAGE_STREAM_LINE_GAP_EN
  parameter int LINE_GAP = 2,
`endif
  parameter int DATA_W   = 16,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int CHANNELS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pic_start,
  input  logic              pic_continuous,
  input  logic              pic_abort,
  output logic              pic_out_valid,
  input  logic              pic_out_ready,
  output logic [DATA_W-1:0] pic_out,
  output logic              pic_sof,
  output logic              pic_eol,
  output logic              pic_eof,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] pic_chan,
  output logic              pic_busy,
  output logic              pic_done
);

  localparam int NPIX   = IMG_W * IMG_H * CHANNELS;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  if ((NPIX > 2**ADDR_W) || (CHAN_W > SB_CHAN_W)) begin : g_size_check
    $error("image_stream_reader: image does not fit the address or channel width");
  end

  state_t              r_state, w_next;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [CHAN_W-1:0]   r_chan;
  logic                r_cont;
  logic                r_rd_vld;
  pix_sb_t             r_rd_sb;
  logic [DATA_W-1:0]   r_fifo_data [2];
  pix_sb_t             r_fifo_sb   [2];
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_count;
  logic                r_done;

  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_rom_data, w_head_data;
  pix_sb_t             w_issue_sb, w_head_sb;
  logic w_last_col, w_last_row, w_last_chan, w_last_pix;
  logic w_room, w_issue, w_start, w_abort;
  logic w_fifo_nempty, w_valid, w_pop, w_fifo_pop, w_push, w_drain_done;

  assign w_last_col  = (r_col  == COL_W'(IMG_W - 1));
  assign w_last_row  = (r_row  == ROW_W'(IMG_H - 1));
  assign w_last_chan = (r_chan == CHAN_W'(CHANNELS - 1));
  assign w_last_pix  = w_last_col && w_last_row && w_last_chan;

  assign w_addr = ADDR_W'(r_chan) * ADDR_W'(IMG_W * IMG_H)
                + ADDR_W'(r_row) * ADDR_W'(IMG_W) + ADDR_W'(r_col);

  assign w_issue_sb.sof  = (r_col == '0) && (r_row == '0) && (r_chan == '0);
  assign w_issue_sb.eol  = w_last_col;
  assign w_issue_sb.eof  = w_last_pix;
  assign w_issue_sb.chan = SB_CHAN_W'(r_chan);

  // Room counts the read already in flight so the FIFO never overflows under backpressure.
  assign w_room  = (r_count == 2'd0) || ((r_count == 2'd1) && !r_rd_vld);
  assign w_start = (r_state == ST_IDLE) && pic_start;
  assign w_abort = (r_state != ST_IDLE) && pic_abort;
  assign w_issue = (r_state == ST_RUN) && w_room && !w_abort;

  // An empty FIFO passes the ROM output straight through to keep first-pixel latency at two.
  assign w_fifo_nempty = (r_count != 2'd0);
  assign w_valid       = w_fifo_nempty || r_rd_vld;
  assign w_head_data   = w_fifo_nempty ? r_fifo_data[r_rd_ptr] : w_rom_data;
  assign w_head_sb     = w_fifo_nempty ? r_fifo_sb[r_rd_ptr]   : r_rd_sb;
  assign w_pop         = w_valid && pic_out_ready;
  assign w_fifo_pop    = w_pop && w_fifo_nempty;
  assign w_push        = r_rd_vld && !(w_pop && !w_fifo_nempty);
  assign w_drain_done  = w_pop && ((r_count + {1'b0, r_rd_vld}) == 2'd1);

  assign pic_out_valid = w_valid;
  assign pic_out       = w_valid ? w_head_data : '0;
  assign pic_sof       = w_valid && w_head_sb.sof;
  assign pic_eol       = w_valid && w_head_sb.eol;
  assign pic_eof       = w_valid && w_head_sb.eof;
  assign pic_chan      = w_valid ? CHAN_W'(w_head_sb.chan) : '0;
  assign pic_busy      = (r_state != ST_IDLE);
  assign pic_done      = r_done;

`ifdef IMAGE_STREAM_LINE_GAP_EN
  localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  logic [GAP_W-1:0] r_gap_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_gap_cnt <= '0;
    else if ((w_next == ST_GAP) && (r_state != ST_GAP))
      r_gap_cnt <= GAP_W'(LINE_GAP - 1);
    else if ((r_state == ST_GAP) && (r_gap_cnt != '0))
      r_gap_cnt <= r_gap_cnt - GAP_W'(1);
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (pic_start) w_next = ST_RUN;
      ST_RUN: begin
        if (w_abort)
          w_next = ST_IDLE;
        else if (w_issue && w_last_pix && !r_cont)
          w_next = ST_DRAIN;
`ifdef IMAGE_STREAM_LINE_GAP_EN
        else if (w_issue && w_last_col && !w_last_pix && (LINE_GAP > 0))
          w_next = ST_GAP;
`endif
      end
      ST_DRAIN: if (w_abort || w_drain_done) w_next = ST_IDLE;
`ifdef IMAGE_STREAM_LINE_GAP_EN
      ST_GAP: begin
        if (w_abort)
          w_next = ST_IDLE;
        else if (r_gap_cnt == '0)
          w_next = ST_RUN;
      end
`endif
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_chan   <= '0;
      r_cont   <= 1'b0;
      r_rd_vld <= 1'b0;
      r_rd_sb  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_abort || ((r_state == ST_DRAIN) && w_drain_done);

      if (w_start) begin
        r_col  <= '0;
        r_row  <= '0;
        r_chan <= '0;
        r_cont <= pic_continuous;
      end else if (w_issue) begin
        if (w_last_pix) begin
          r_col  <= '0;
          r_row  <= '0;
          r_chan <= '0;
        end else if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row  <= '0;
            r_chan <= r_chan + CHAN_W'(1);
          end else begin
            r_row <= r_row + ROW_W'(1);
          end
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      if (w_abort) begin
        r_rd_vld <= 1'b0;
        r_count  <= 2'd0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        r_rd_vld <= w_issue;
        r_rd_sb  <= w_issue_sb;
        if (w_push)     r_wr_ptr <= ~r_wr_ptr;
        if (w_fifo_pop) r_rd_ptr <= ~r_rd_ptr;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!w_abort && w_push) begin
      r_fifo_data[r_wr_ptr] <= w_rom_data;
      r_fifo_sb[r_wr_ptr]   <= r_rd_sb;
    end
  end

  image_rom_sync #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE("")
  ) u_rom (
    .clk   (clk),
    .i_addr(w_addr),
    .o_data(w_rom_data)
  );

endmodule

// File: doc/image_stream_reader.md
Name: image_stream_reader

Overview:
- Parametrised successor to the single-shot 32x32 picture ROM streamer.
- Reads a multi-channel image (channel-planar, row-major) from an internal synchronous ROM and presents it as a valid/ready pixel stream, with frame and line markers.
- Supports backpressure, single-shot or continuous frame modes, and abort.
- Sits between the image ROM and the first convolution layer's input window buffer.

Parameters:
- DATA_W, 16, pixel width in bits
- IMG_W, 32, pixels per row
- IMG_H, 32, rows per channel plane
- CHANNELS, 1, number of channel planes per frame
- ADDR_W, $clog2(IMG_W*IMG_H*CHANNELS), ROM address width (derived, not overridden)
- LINE_GAP, 2, idle cycles inserted after each row (only with optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- pic_start  in  1  one-cycle pulse; begins a frame when idle
- pic_continuous  in  1  sampled at start; 1 = restart frames back-to-back until abort
- pic_abort  in  1  one-cycle pulse; terminates the current frame
- pic_out_valid  out  1  pixel valid
- pic_out_ready  in  1  downstream accepts the pixel when valid&&ready
- pic_out  out  DATA_W  pixel data; forced to 0 when valid=0
- pic_sof  out  1  first pixel of the frame (ch0, row0, col0)
- pic_eol  out  1  last pixel of a row
- pic_eof  out  1  last pixel of the frame
- pic_chan  out  $clog2(CHANNELS)>0?:1  channel index of the current pixel
- pic_busy  out  1  high from the accepted start until the frame ends or drain completes
- pic_done  out  1  one-cycle pulse after the last pixel of a single-shot frame, or after an abort, is accepted or flushed

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0; skid buffer empty. Reset mid-frame discards everything, and the next cycle is idle.
- FSM states: IDLE, RUN, DRAIN, and GAP (GAP exists only with the optional feature).
- IDLE -> RUN: on pic_start. Counters (col, row, chan) clear and pic_continuous is latched. pic_start is ignored while busy.
- RUN: each issue cycle presents the ROM address chan*IMG_W*IMG_H + row*IMG_W + col.
  - The ROM has 1-cycle read latency.
  - Issue occurs only when the 2-entry output skid FIFO has room counting the in-flight read, so no pixel is ever lost under backpressure.
  - col wraps at IMG_W-1 and increments row. row wraps at IMG_H-1 and increments chan.
- After issuing the final address:
  - Continuous mode: counters wrap to 0 and RUN continues with no bubble.
  - Single-shot: go to DRAIN.
- DRAIN -> IDLE: once the FIFO is empty and no read is in flight. pic_done pulses the cycle after the last handshake.
- Markers: sof, eol, eof and chan travel with each pixel through the ROM latency and the FIFO.
  - eol is set when col == IMG_W-1.
  - eof is set on the final pixel of the frame.
  - In continuous mode, sof reasserts on every frame.
- First output: the first pixel reaches valid 2 cycles after pic_start (1 cycle issue, 1 cycle ROM).
- Throughput: 1 pixel/cycle while ready stays high.
- Output stability: while valid && !ready, pic_out and all markers hold stable.
- pic_abort:
  - Stops issuing.
  - Flushes the FIFO and drops the in-flight read.
  - valid is 0 the next cycle.
  - pic_done pulses, then IDLE.
  - Abort while idle has no effect.
  - Abort and start in the same cycle: abort wins when busy; start wins when idle.
- Width rule: address arithmetic is done at ADDR_W bits, and the elaboration check requires IMG_W*IMG_H*CHANNELS <= 2**ADDR_W.

Optional Feature:
- Macro: IMAGE_STREAM_LINE_GAP_EN.
- Defined: after the eol pixel is issued, the FSM enters GAP for LINE_GAP cycles with no issue, then returns to RUN. No gap follows the eof pixel. Abort is honoured in GAP. This models sensor horizontal blanking.
- Undefined: the GAP state and LINE_GAP logic are absent, and rows stream back-to-back.

Decomposition:
- Package image_stream_pkg: FSM state enum, and a pixel sideband struct {sof, eol, eof, chan}.
- Sub-module image_rom_sync: a generic DATA_W x 2**ADDR_W synchronous ROM with 1-cycle latency and a init-file parameter. It wraps the vendor ROM IP and gives a behavioural model in simulation.
- The skid FIFO stays inline.

Test Plan:
- Single-shot, IMG_W=4, IMG_H=2, CHANNELS=2, ready=1, ROM[i]=i: start -> 16 pixels 0..15 on consecutive cycles starting 2 cycles after start. sof on 0; eol on 3,7,11,15; eof on 15; chan=1 for pixels 8..15. pic_done one cycle after pixel 15.
- Same config with ready toggling 1,0,0,1 randomly: identical pixel order and markers, no drops or duplicates, and data stable during stalls.
- Continuous mode, 3 frames, then abort mid-frame 4 at pixel 5: the sequence repeats 0..15 with no bubble, sof at each frame start. After abort, valid=0 the next cycle, pic_done pulses, and busy falls.
- pic_start while busy, and start+abort in the same idle cycle: the busy start is ignored; the idle case starts a frame.
- Reset asserted at pixel 6 for 1 cycle: all outputs 0 the next cycle. A new start yields a full frame from pixel 0.
- With IMAGE_STREAM_LINE_GAP_EN, LINE_GAP=2: exactly 2 valid-low cycles after each eol except after eof; frame data unchanged.
